// File: rtl/sat_ammo_counter.sv
// rtl/sat_ammo_counter.sv - saturating up/down ammo counter with loadable maximum
//
// Purpose:
//   Holds a loadable maximum and an ammo count. The count climbs by 1 up to
//   the maximum, or drops by a rate down to 0, and can be loaded directly.
//   The datapath is built from one-hot AND-OR muxes feeding two registers
//   that share an asynchronous reset.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous, active-high reset (clears count and maximum)
//   i_up        increment request
//   i_down      decrement-by-rate request (fire)
//   i_load      load count from i_in
//   i_load_max  one-hot max select: 2'b01 hold, 2'b10 load from i_in
//   i_in        load value for count and maximum
//   i_rate      decrement step
//   o_out       current count (registered)
//   o_max_out   current maximum (registered)
//   o_empty     combinational, o_out == 0

module sat_ammo_counter #(
  parameter int N = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_load,
  input  logic [1:0]   i_load_max,
  input  logic [N-1:0] i_in,
  input  logic [N-1:0] i_rate,
  output logic [N-1:0] o_out,
  output logic [N-1:0] o_max_out,
  output logic         o_empty
);

  // One-hot AND-OR mux, select bit s[i] picks ai.
  function automatic logic [N-1:0] mux2(
    input logic [1:0]   s,
    input logic [N-1:0] a1,
    input logic [N-1:0] a0
  );
    return ({N{s[1]}} & a1) | ({N{s[0]}} & a0);
  endfunction

  function automatic logic [N-1:0] mux4(
    input logic [3:0]   s,
    input logic [N-1:0] a3,
    input logic [N-1:0] a2,
    input logic [N-1:0] a1,
    input logic [N-1:0] a0
  );
    return ({N{s[3]}} & a3) | ({N{s[2]}} & a2) |
           ({N{s[1]}} & a1) | ({N{s[0]}} & a0);
  endfunction

  logic [N-1:0] r_out;
  logic [N-1:0] r_max;

  logic [1:0]   w_max_sel;
  logic [N-1:0] w_max_next;
  logic [N-1:0] w_dec;
  logic [N-1:0] w_inc;
  logic [N-1:0] w_step;
  logic [3:0]   w_cnt_sel;
  logic [N-1:0] w_cnt_next;

  // Any code other than 2'b10 holds, so the mux select is always one-hot.
  always_comb begin
    w_max_sel = 2'b01;
    if (i_load_max == 2'b10) begin
      w_max_sel = 2'b10;
    end
  end

  assign w_max_next = mux2(w_max_sel, i_in, r_max);

  // Decrement saturates at 0 instead of wrapping.
  assign w_dec = (r_out >= i_rate) ? (r_out - i_rate) : {N{1'b0}};

  // Increment clamps to the current (pre-edge) maximum; a count above the
  // maximum after a load is pulled back down to it. r_out < r_max guarantees
  // r_out + 1 cannot overflow.
  assign w_inc = (r_out < r_max) ? (r_out + N'(1)) : r_max;

  // Down wins over up when both are requested.
  assign w_step = mux2({i_down, ~i_down}, w_dec, w_inc);

  // Count select {hold, load, step, rst}, resolved in priority order so that
  // exactly one bit is ever set.
  always_comb begin
    w_cnt_sel = 4'b1000;
    if (i_rst) begin
      w_cnt_sel = 4'b0001;
    end else if (i_load) begin
      w_cnt_sel = 4'b0100;
    end else if (i_up || i_down) begin
      w_cnt_sel = 4'b0010;
    end
  end

  assign w_cnt_next = mux4(w_cnt_sel, r_out, i_in, w_step, {N{1'b0}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_max <= {N{1'b0}};
    end else begin
      r_max <= w_max_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out <= {N{1'b0}};
    end else begin
      r_out <= w_cnt_next;
    end
  end

  assign o_out     = r_out;
  assign o_max_out = r_max;
  assign o_empty   = (r_out == {N{1'b0}});

endmodule

// File: tb/tb_sat_ammo_counter.sv
// tb/tb_sat_ammo_counter.sv - self-checking bench for sat_ammo_counter

module tb_sat_ammo_counter;

  localparam int N = 9;

  logic         clk;
  logic         rst;
  logic         up;
  logic         down;
  logic         load;
  logic [1:0]   load_max;
  logic [N-1:0] in_val;
  logic [N-1:0] rate;
  logic [N-1:0] out;
  logic [N-1:0] max_out;
  logic         empty;

  int checks = 0;
  int errors = 0;

  int m_out = 0;
  int m_max = 0;

  sat_ammo_counter #(.N(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_up       (up),
    .i_down     (down),
    .i_load     (load),
    .i_load_max (load_max),
    .i_in       (in_val),
    .i_rate     (rate),
    .o_out      (out),
    .o_max_out  (max_out),
    .o_empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".max"}, 32'(max_out), 32'(m_max));
    chk({tag, ".empty"}, 32'(empty), (m_out == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input logic u, input logic d, input logic l,
                       input logic [1:0] lm, input int v, input int r);
    up       = u;
    down     = d;
    load     = l;
    load_max = lm;
    in_val   = N'(v);
    rate     = N'(r);
  endtask

  // Reference: next state from the current model state and the inputs.
  task automatic tick(input string tag);
    int n_out;
    int n_max;
    n_out = m_out;
    n_max = m_max;
    if (load) begin
      n_out = int'(in_val);
    end else if (down) begin
      n_out = (m_out - int'(rate) < 0) ? 0 : m_out - int'(rate);
    end else if (up) begin
      n_out = (m_out + 1 > m_max) ? m_max : m_out + 1;
    end
    if (load_max == 2'b10) begin
      n_max = int'(in_val);
    end
    @(posedge clk);
    #1;
    m_out = n_out;
    m_max = n_max;
    chk_all(tag);
  endtask

  // Async reset pulse: entered 1 time unit after an edge, left the same way.
  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_out = 0;
    m_max = 0;
    chk_all({tag, ".imm"});
    @(posedge clk);
    #1;
    chk_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 2'b01, 0, 0);
    #12;
    chk_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load maximum, then count.
    drive(0, 0, 0, 2'b10, 300, 0);
    tick("ldmax");
    chk("ldmax.300", 32'(max_out), 32'd300);
    drive(0, 0, 1, 2'b01, 100, 0);
    tick("ldcnt");
    chk("ldcnt.100", 32'(out), 32'd100);

    // Async reset mid-count with no clock edge.
    drive(0, 0, 1, 2'b01, 37, 0);
    tick("ld37");
    drive(0, 0, 0, 2'b01, 0, 0);
    async_reset_pulse("rst37");

    // max = 5, out = 3, up held: 4, 5, 5, 5.
    drive(0, 0, 1, 2'b10, 5, 0);
    tick("set5");
    drive(0, 0, 1, 2'b01, 3, 0);
    tick("set3");
    drive(1, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 4; i++) tick($sformatf("up%0d", i));
    chk("up.clamp", 32'(out), 32'd5);

    // out = 10, rate = 4, down held: 6, 2, 0, 0.
    drive(0, 0, 1, 2'b10, 300, 0);
    tick("ld10max");
    drive(0, 0, 1, 2'b01, 10, 0);
    tick("ld10");
    drive(0, 1, 0, 2'b01, 0, 4);
    for (int i = 0; i < 4; i++) tick($sformatf("dn%0d", i));
    chk("dn.empty", 32'(empty), 32'd1);

    // Both up and down: down wins. Load and down: load wins.
    drive(0, 0, 1, 2'b01, 8, 0);
    tick("ld8");
    drive(1, 1, 0, 2'b01, 0, 3);
    tick("updn");
    chk("updn.5", 32'(out), 32'd5);
    drive(0, 1, 1, 2'b01, 50, 3);
    tick("lddn");
    chk("lddn.50", 32'(out), 32'd50);

    // Idle holds; rate = 0 leaves count unchanged.
    drive(0, 0, 1, 2'b01, 42, 0);
    tick("ld42");
    drive(0, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 5; i++) tick($sformatf("idle%0d", i));
    chk("idle.42", 32'(out), 32'd42);
    drive(0, 1, 0, 2'b01, 0, 0);
    tick("rate0");

    // Load above max is kept; up pulls it back down to max.
    drive(0, 0, 1, 2'b10, 5, 0);
    tick("setmax5");
    drive(0, 0, 1, 2'b01, 100, 0);
    tick("over");
    chk("over.100", 32'(out), 32'd100);
    drive(1, 0, 0, 2'b11, 0, 0);
    tick("pull");
    chk("pull.5", 32'(out), 32'd5);

    // Same-edge max change: up compares against the old maximum.
    drive(1, 0, 0, 2'b10, 9, 0);
    tick("oldmax");
    chk("oldmax.out", 32'(out), 32'd5);
    chk("oldmax.max", 32'(max_out), 32'd9);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] lm;
      case ($urandom_range(0, 7))
        0, 1:    lm = 2'b10;
        2:       lm = 2'b00;
        3:       lm = 2'b11;
        default: lm = 2'b01;
      endcase
      up       = ($urandom_range(0, 1) == 1);
      down     = ($urandom_range(0, 2) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_max = lm;
      in_val   = N'($urandom_range(0, 511));
      rate     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 511))
                                             : N'($urandom_range(0, 20));
      if ($urandom_range(0, 59) == 0) begin
        async_reset_pulse($sformatf("rrst%0d", i));
      end else begin
        tick($sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_ammo_counter.md
Name: sat_ammo_counter

Overview:
- Parameterised saturating up/down counter for the weapons ammo path.
- Holds a loadable maximum (`max`) and a count (`out`); the count increments by 1 up to `max`, or decrements by `rate` down to 0.
- Built from the codebase primitives: DFF (N-bit register), Mux2 (2:1 one-hot mux) and Mux4 (4:1 one-hot mux), here extended with asynchronous reset on the registers.
- Sits under the weapons controller, which drives `down` with the fire command and `in` with the reload amount.

Parameters:
- N, 9, width of count, maximum, input value and rate.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- up  input  1  increment request
- down  input  1  decrement-by-rate request (fire)
- load  input  1  load count from in
- load_max  input  2  one-hot max-register select: 2'b01 = hold max; 2'b10 = max <= in
- in  input  N  load value for count and for max
- rate  input  N  decrement step
- out  output  N  current count (registered)
- max_out  output  N  current maximum (registered)
- empty  output  1  combinational, out == 0

Behaviour:
- Mux2 / Mux4 are one-hot AND-OR muxes: output = OR of inputs whose select bit is 1.
  - Select bit s[i] picks input ai; Mux4 argument order is a3, a2, a1, a0.
  - All-zero select yields 0.
  - Multiple select bits set yields the OR of the selected inputs.
  - Control logic must always generate exactly one-hot selects.
- Both registers are DFF-based, update on the rising edge of clk, and share the same reset.
- rst asserted (asynchronously, no clock needed): out = 0 and max_out = 0 immediately; both stay 0 while rst is high.
- First update after rst deasserts happens on the next rising clk edge.
- Max register, per clock edge when rst = 0:
  - load_max = 10: max <= in.
  - load_max = 01 (or any other code): max holds.
- Count next-state, via Mux4 with one-hot select {hold, load, step, rst}, in strict priority:
  - rst -> 0
  - else load -> in (not clamped to max)
  - else up or down -> step value
  - else hold
- Step value:
  - If down = 1 (down wins over up when both are high): out - rate when out >= rate; otherwise 0 (saturate, no wrap).
  - Else (up = 1): out + 1 when out < max; otherwise max (clamp; if out > max after a load, up pulls out down to max).
- rate = 0 with down: count unchanged.
- Same-edge load_max and count update: the count step compares against the old max (the register value before the edge).
- Latency: one clock from input to out / max_out. empty follows out combinationally.
- No X propagation: every register is defined after reset.

Test Plan:
- rst pulse mid-count (out = 37) with no clk edge -> out = 0, max_out = 0, empty = 1 immediately.
- load_max = 10, in = 300, then load = 1, in = 100 -> max_out = 300 after edge 1, out = 100 after edge 2.
- With max = 5 and out = 3, up held for 4 edges -> out: 4, 5, 5, 5.
- With out = 10 and rate = 4, down held for 4 edges -> out: 6, 2, 0, 0; empty = 1 at the end.
- up and down both high, out = 8, rate = 3 -> out = 5 (down wins); load and down both high, in = 50 -> out = 50 (load wins).
- All controls idle for 5 edges with out = 42 -> out stays 42; rate = 0 with down -> out unchanged.
